// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//
// Instruction memory with a byte-stream boot loader in front of a single-cycle
// core. After reset the block holds the core in reset and collects a program
// image as a little-endian byte stream over a valid/ready handshake. It packs
// the bytes into 32-bit words and writes them to consecutive words of memory.
// On a clean end of image it releases the core and serves as a
// combinational-read instruction ROM. A truncated or oversized image parks the
// block in ERROR with the core still held in reset.
//
// Parameters
//   DEPTH       memory size in 32-bit words (power of two, >= 4)
//   NOP         word returned for unloaded / out-of-range / misaligned fetches
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   ld_valid     loader byte valid
//   ld_ready     loader can accept a byte this cycle
//   ld_byte      image byte (little-endian within a word, ascending address)
//   ld_last      marks the final image byte (qualified by the handshake)
//   address      core PC (byte address)
//   instruction  instruction word to the core (combinational from address)
//   core_reset   reset to the core, high until a good image is loaded
//   load_done    image loaded, core running
//   load_err     image rejected, core held in reset
//   word_count   number of words written
// -----------------------------------------------------------------------------
module instr_mem_loader #(
    parameter int          DEPTH = 1024,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [7:0]               ld_byte,
    input  logic                     ld_last,
    input  logic [31:0]              address,
    output logic [31:0]              instruction,
    output logic                     core_reset,
    output logic                     load_done,
    output logic                     load_err,
    output logic [$clog2(DEPTH):0]   word_count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    // Only lanes 0..2 need holding; lane 3 arrives with the write itself.
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;

    logic [31:0]       mem [DEPTH];

    logic              accept_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [31:0]       mem_wdata_s;
    logic [31:0]       word_in_s;

    logic [ADDR_W-1:0] fetch_idx_s;
    logic              fetch_hit_s;

    // Handshake and status outputs; reset overrides state so the core sees
    // reset in the very cycle reset is raised.
    always_comb begin
        ld_ready   = (state_q == S_LOAD) && !reset;
        core_reset = (state_q != S_RUN) || reset;
        load_done  = (state_q == S_RUN) && !reset;
        load_err   = (state_q == S_ERROR) && !reset;
        if (reset) begin
            word_count = '0;
        end else begin
            word_count = word_count_q;
        end
    end

    assign accept_s = ld_valid && ld_ready;

    // Loader next-state: byte assembly, word writes and termination checks.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        word_count_d = word_count_q;
        mem_we_s     = 1'b0;
        mem_waddr_s  = word_count_q[ADDR_W-1:0];
        mem_wdata_s  = 32'h0000_0000;

        // Lanes above the current one are always zero in asm_q (cleared after
        // every word write), so a partial word is zero-padded for free.
        word_in_s = {8'h00, asm_q};
        case (lane_q)
            2'd0:    word_in_s[7:0]   = ld_byte;
            2'd1:    word_in_s[15:8]  = ld_byte;
            2'd2:    word_in_s[23:16] = ld_byte;
            default: word_in_s[31:24] = ld_byte;
        endcase

        case (state_q)
            S_LOAD: begin
                if (accept_s) begin
                    if (word_count_q == DEPTH_C) begin
                        // Image longer than memory: drop the byte and reject.
                        state_d = S_ERROR;
                    end else if ((lane_q == 2'd3) || ld_last) begin
                        mem_we_s     = 1'b1;
                        mem_wdata_s  = word_in_s;
                        word_count_d = word_count_q + ONE_C;
                        lane_d       = 2'd0;
                        asm_d        = 24'h00_0000;
                        if (ld_last) begin
                            if (lane_q == 2'd3) begin
                                state_d = S_RUN;
                            end else begin
                                state_d = S_ERROR;
                            end
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        asm_d  = word_in_s[23:0];
                        lane_d = lane_q + 2'd1;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    // Loader state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            lane_q       <= 2'd0;
            asm_q        <= 24'h00_0000;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            word_count_q <= word_count_d;
        end
    end

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Combinational fetch with alignment, range and loaded-word filtering.
    always_comb begin
        fetch_idx_s = address[ADDR_W+1:2];
        fetch_hit_s = (state_q == S_RUN) && !reset
                   && (address[1:0] == 2'b00)
                   && (address[31:ADDR_W+2] == '0)
                   && ({1'b0, fetch_idx_s} < word_count_q);
        if (fetch_hit_s) begin
            instruction = mem[fetch_idx_s];
        end else begin
            instruction = NOP;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic [31:0] address;
    logic [31:0] instruction;
    logic        core_reset;
    logic        load_done;
    logic        load_err;
    logic [2:0]  word_count;

    instr_mem_loader #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_byte     (ld_byte),
        .ld_last     (ld_last),
        .address     (address),
        .instruction (instruction),
        .core_reset  (core_reset),
        .load_done   (load_done),
        .load_err    (load_err),
        .word_count  (word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          idx;
        logic [31:0] w;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_lane;
    int          m_idx;
    logic [31:0] m_word;

    task automatic model_clear();
        m_lane = 0;
        m_idx  = 0;
        m_word = 32'h0000_0000;
        sb.delete();
    endtask

    // Drive one byte (after `gap` idle cycles) and wait for it to be accepted.
    // Called and returns at a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int t;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        repeat (gap) @(negedge clk);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        t = 0;
        while (ld_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (ld_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: ld_ready=%b required 1 within 20 cycles", ld_ready);
        end else begin
            @(posedge clk);
            if (m_idx < DEPTH) begin
                m_word[m_lane*8 +: 8] = b;
                if (m_lane == 3 || last) begin
                    sb.push_back('{idx: m_idx, w: m_word});
                    m_idx++;
                    m_lane = 0;
                    m_word = 32'h0000_0000;
                end else begin
                    m_lane++;
                end
            end
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic apply_reset(input logic hold_valid);
        reset    = 1'b1;
        ld_valid = hold_valid;
        ld_byte  = 8'hFF;
        ld_last  = hold_valid;
        #1;
        n_tests++;
        if (core_reset !== 1'b1 || ld_ready !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL in_reset: core_reset=%b ld_ready=%b done=%b err=%b required 1 0 0 0",
                     core_reset, ld_ready, load_done, load_err);
        end
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if (word_count !== 3'd0 || ld_ready !== 1'b1 || core_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: word_count=%0d ld_ready=%b core_reset=%b required 0 1 1",
                     word_count, ld_ready, core_reset);
        end
        @(negedge clk);
    endtask

    // Pop expected words and compare through the fetch port.
    task automatic drain_fetch(input string name);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            address = 32'(e.idx * 4);
            #1;
            n_tests++;
            if (instruction !== e.w) begin
                n_fail++;
                $display("FAIL %s fetch@%h: got %h required %h", name, address, instruction, e.w);
            end
            @(negedge clk);
        end
    endtask

    // Pop expected words and compare the array directly (fetch is masked).
    task automatic drain_mem(input string name);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (dut.mem[e.idx] !== e.w) begin
                n_fail++;
                $display("FAIL %s mem[%0d]: got %h required %h", name, e.idx, dut.mem[e.idx], e.w);
            end
        end
    endtask

    task automatic check_nop(input string name, input logic [31:0] a);
        address = a;
        #1;
        n_tests++;
        if (instruction !== NOP) begin
            n_fail++;
            $display("FAIL %s nop@%h: got %h required %h", name, a, instruction, NOP);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_byte  = 8'h00;
        ld_last  = 1'b0;
        address  = 32'h0;
        @(negedge clk);
        n_tests++;
        if (ld_ready !== 1'b0 || core_reset !== 1'b1 || load_done !== 1'b0 ||
            load_err !== 1'b0 || word_count !== 3'd0 || instruction !== NOP) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b crst=%b done=%b err=%b wc=%0d instr=%h required 0 1 0 0 0 %h",
                     ld_ready, core_reset, load_done, load_err, word_count, instruction, NOP);
        end
        reset = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if (ld_ready !== 1'b1 || core_reset !== 1'b1 || load_done !== 1'b0 ||
            word_count !== 3'd0 || instruction !== NOP) begin
            n_fail++;
            $display("FAIL post_reset: rdy=%b crst=%b done=%b wc=%0d instr=%h required 1 1 0 0 %h",
                     ld_ready, core_reset, load_done, word_count, instruction, NOP);
        end
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        logic [7:0] img [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        address = 32'h0;
        for (int i = 0; i < 8; i++) send_byte(img[i], (i == 7), 0);
        n_tests++;
        if (core_reset !== 1'b0 || load_done !== 1'b1 || ld_ready !== 1'b0 || instruction !== 32'h0010_0513) begin
            n_fail++;
            $display("FAIL basic_release: crst=%b done=%b rdy=%b instr=%h required 0 1 0 00100513",
                     core_reset, load_done, ld_ready, instruction);
        end
        n_tests++;
        if (word_count !== 3'd2) begin
            n_fail++;
            $display("FAIL basic_count: got %0d required 2", word_count);
        end
        drain_fetch("basic");
        check_nop("basic", 32'h8);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] img [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        apply_reset(1'b1);
        for (int i = 0; i < 8; i++) send_byte(img[i], (i == 7), int'($urandom_range(0, 3)));
        n_tests++;
        if (load_done !== 1'b1 || ld_ready !== 1'b0 || word_count !== 3'd2) begin
            n_fail++;
            $display("FAIL gaps_state: done=%b rdy=%b wc=%0d required 1 0 2", load_done, ld_ready, word_count);
        end
        drain_fetch("gaps");
    endtask

    task automatic test_partial();
        logic [7:0] img [6] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'hAA, 8'hBB};
        apply_reset(1'b0);
        for (int i = 0; i < 6; i++) send_byte(img[i], (i == 5), 0);
        n_tests++;
        if (load_err !== 1'b1 || core_reset !== 1'b1 || load_done !== 1'b0 ||
            word_count !== 3'd2 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_state: err=%b crst=%b done=%b wc=%0d rdy=%b required 1 1 0 2 0",
                     load_err, core_reset, load_done, word_count, ld_ready);
        end
        drain_mem("partial");
        check_nop("partial", 32'h0);
        check_nop("partial", 32'h4);
        check_nop("partial", 32'h8);
        @(negedge clk);
    endtask

    task automatic test_overflow();
        apply_reset(1'b0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), (i == 15), 0);
        n_tests++;
        if (load_done !== 1'b1 || word_count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_exact: done=%b wc=%0d required 1 4", load_done, word_count);
        end
        drain_fetch("ovf_exact");
        apply_reset(1'b0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hC0 + i), 1'b0, 0);
        n_tests++;
        if (load_err !== 1'b0 || ld_ready !== 1'b1 || word_count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_full: err=%b rdy=%b wc=%0d required 0 1 4", load_err, ld_ready, word_count);
        end
        send_byte(8'hEE, 1'b0, 0);
        n_tests++;
        if (load_err !== 1'b1 || core_reset !== 1'b1 || word_count !== 3'd4 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_err: err=%b crst=%b wc=%0d rdy=%b required 1 1 4 0",
                     load_err, core_reset, word_count, ld_ready);
        end
        drain_mem("ovf");
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] img [4] = '{8'h33, 8'h00, 8'h00, 8'h00};
        apply_reset(1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h70 + i), 1'b0, 0);
        apply_reset(1'b0);
        for (int i = 0; i < 4; i++) send_byte(img[i], (i == 3), 0);
        n_tests++;
        if (load_done !== 1'b1 || word_count !== 3'd1) begin
            n_fail++;
            $display("FAIL midrst_state: done=%b wc=%0d required 1 1", load_done, word_count);
        end
        drain_fetch("midrst");
        check_nop("midrst", 32'h4);
        @(negedge clk);
    endtask

    task automatic test_fetch_filter();
        check_nop("filter_misaligned", 32'h2);
        check_nop("filter_range", 32'(4 * DEPTH));
        check_nop("filter_high", 32'h8000_0000);
        address = 32'h0;
        #1;
        n_tests++;
        if (instruction !== 32'h0000_0033) begin
            n_fail++;
            $display("FAIL filter_hit: got %h required 00000033", instruction);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_backpressure();
        test_partial();
        test_overflow();
        test_reset_mid_load();
        test_fetch_filter();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
